// File: rtl/shift_seq_unit.sv
// shift_seq_unit: multi-cycle shifter/rotator, one bit per clock, with a registered result and done pulse.
// Revision 1.0 - initial release.
`default_nettype none

module shift_seq_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [1:0]         shamt_sel,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [DATA_W-1:0]  b_data,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic [SHAMT_W-1:0] instr_shamt,
  output logic [DATA_W-1:0]  result,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  logic [1:0]         state_q,  state_d;
  logic [SHAMT_W-1:0] cnt_q,    cnt_d;
  logic [DATA_W-1:0]  work_q,   work_d;
  logic [2:0]         op_q,     op_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               done_q,   done_d;
  logic [SHAMT_W-1:0] amt;

  // Upper amount bits are architecturally don't-care.
  logic unused_upper;
  assign unused_upper = ^{b_data[DATA_W-1:SHAMT_W], mem_data[DATA_W-1:SHAMT_W]};

  always_comb begin
    amt = '0;
    case (shamt_sel)
      2'b00:   amt = b_data[SHAMT_W-1:0];
      2'b01:   amt = mem_data[SHAMT_W-1:0];
      2'b10:   amt = instr_shamt;
      default: amt = '0;
    endcase
  end

  function automatic logic [DATA_W-1:0] step1(input logic [2:0] o, input logic [DATA_W-1:0] v);
    case (o)
      OP_SLL:  step1 = {v[DATA_W-2:0], 1'b0};
      OP_SRL:  step1 = {1'b0, v[DATA_W-1:1]};
      OP_SRA:  step1 = {v[DATA_W-1], v[DATA_W-1:1]};
      OP_ROL:  step1 = {v[DATA_W-2:0], v[DATA_W-1]};
      OP_ROR:  step1 = {v[0], v[DATA_W-1:1]};
      default: step1 = v;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    op_d     = op_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          work_d = data_in;
          cnt_d  = amt;
          // Zero amount and pass-through ops complete without any shift steps.
          if (amt == '0 || op > OP_ROR) begin
            state_d  = S_DONE;
            result_d = data_in;
            done_d   = 1'b1;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = step1(op_q, work_q);
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d  = S_DONE;
          result_d = work_d;
          done_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      op_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      op_q     <= op_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q == S_SHIFT) || (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_unit.sv
// tb_shift_seq_unit: scoreboard bench for shift_seq_unit with directed and random shifts.
`default_nettype none

module tb_shift_seq_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [1:0]  shamt_sel = '0;
  logic [31:0] data_in = '0;
  logic [31:0] b_data = '0;
  logic [31:0] mem_data = '0;
  logic [4:0]  instr_shamt = '0;
  logic [31:0] result;
  logic        busy;
  logic        done;

  shift_seq_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt_sel(shamt_sel),
    .data_in(data_in), .b_data(b_data), .mem_data(mem_data), .instr_shamt(instr_shamt),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          issue;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse retires one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: result=%h, no start outstanding", result);
      end else begin
        e = sb.pop_front();
        n_vec++;
        if (result !== e.res) begin
          n_err++;
          $display("FAIL result: got %h expected %h", result, e.res);
        end
        n_vec++;
        if (cyc - e.issue != e.lat) begin
          n_err++;
          $display("FAIL latency: got %0d expected %0d", cyc - e.issue, e.lat);
        end
      end
    end
    if (done && done_prev) begin
      n_vec++; n_err++;
      $display("FAIL done_width: done high two cycles in a row");
    end
    done_prev = done;
  end

  function automatic logic [31:0] ref_shift(input logic [2:0] o, input int n, input logic [31:0] d);
    case (o)
      3'd0:    return d << n;
      3'd1:    return d >> n;
      3'd2:    return $unsigned($signed(d) >>> n);
      3'd3:    return (n == 0) ? d : ((d << n) | (d >> (32 - n)));
      3'd4:    return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
      default: return d;
    endcase
  endfunction

  function automatic int ref_amount(input logic [1:0] s, input logic [31:0] b,
                                    input logic [31:0] m, input logic [4:0] ish);
    case (s)
      2'b00:   return int'(b[4:0]);
      2'b01:   return int'(m[4:0]);
      2'b10:   return int'(ish);
      default: return 0;
    endcase
  endfunction

  // Issue one start; optionally pulse a stray start one cycle later (must be ignored).
  task automatic run(input logic [2:0] o, input logic [1:0] s, input logic [31:0] d,
                     input logic [31:0] b, input logic [31:0] m, input logic [4:0] ish,
                     input logic [31:0] exp_res, input int exp_lat, input bit stray);
    exp_t e;
    @(negedge clk);
    op = o; shamt_sel = s; data_in = d; b_data = b; mem_data = m; instr_shamt = ish;
    start = 1'b1;
    e.res = exp_res; e.issue = cyc; e.lat = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (stray) begin
      op = 3'd0; shamt_sel = 2'b10; data_in = $urandom; instr_shamt = 5'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL timeout: done not seen, %0d entries pending", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  initial begin
    logic [2:0]  o;
    logic [1:0]  s;
    logic [31:0] d, b, m, r31;
    logic [4:0]  ish;
    int          n;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    reset = 1'b0;

    run(3'd0, 2'b10, 32'h000000F1, 32'h0, 32'h0, 5'd4, 32'h00000F10, 5, 1'b0);
    run(3'd2, 2'b00, 32'h80000000, 32'hFFFFFFE3, 32'h0, 5'd0, 32'hF0000000, 4, 1'b0);
    run(3'd4, 2'b01, 32'h00000001, 32'h0, 32'h00000021, 5'd0, 32'h80000000, 2, 1'b1);
    for (int k = 0; k < 8; k++)
      run(3'(k), 2'b11, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'h12345678, 1, 1'b0);
    // Start held during the DONE cycle of a zero-length op is not accepted.
    run(3'd5, 2'b10, 32'hCAFEF00D, 32'h0, 32'h0, 5'd9, 32'hCAFEF00D, 1, 1'b1);

    // Wrap consistency: ROL 31 then ROL 1 restores the operand.
    d = 32'h9ABC0123;
    r31 = 32'hCD5E0091;
    run(3'd3, 2'b10, d, 32'h0, 32'h0, 5'd31, r31, 32, 1'b0);
    run(3'd3, 2'b10, r31, 32'h0, 32'h0, 5'd1, d, 2, 1'b0);

    // Reset in the third SHIFT cycle abandons the shift.
    @(negedge clk);
    op = 3'd1; shamt_sel = 2'b10; instr_shamt = 5'd10; data_in = 32'hFFFF0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_result", result, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    repeat (12) @(negedge clk);
    run(3'd1, 2'b10, 32'h00000002, 32'h0, 32'h0, 5'd1, 32'h00000001, 2, 1'b0);

    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(0, 7));
      s = 2'($urandom_range(0, 3));
      d = $urandom; b = $urandom; m = $urandom; ish = 5'($urandom);
      n = ref_amount(s, b, m, ish);
      run(o, s, d, b, m, ish, ref_shift(o, n, d),
          (n == 0 || o > 3'd4) ? 1 : n + 1, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_seq_unit.md
SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the operand and result width, a power of two and at least 8.
REQ-002 SHALL have parameter SHAMT_W, default 5, the shift-amount width, equal to log2(DATA_W).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a shift, sampled only in IDLE.
REQ-006 SHALL have port op, input, 3 bits: operation select; 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through.
REQ-007 SHALL have port shamt_sel, input, 2 bits: shift-amount source; 00 b_data, 01 mem_data, 10 instr_shamt, 11 constant zero.
REQ-008 SHALL have port data_in, input, DATA_W bits: the operand to shift.
REQ-009 SHALL have port b_data, input, DATA_W bits: register B value used as an amount source.
REQ-010 SHALL have port mem_data, input, DATA_W bits: memory data-out used as an amount source.
REQ-011 SHALL have port instr_shamt, input, SHAMT_W bits: the instruction shamt field, instruction[10:6] at default width.
REQ-012 SHALL have port result, output, DATA_W bits: the shifted value, registered.
REQ-013 SHALL have port busy, output, 1 bit: high in states SHIFT and DONE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse, registered.

Function
REQ-015 SHALL take the amount from the low SHAMT_W bits of b_data or mem_data when those sources are selected; upper bits SHALL be ignored.
REQ-016 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-017 SHALL, in IDLE with start=1, capture data_in, op and the selected amount N at that edge, and SHALL ignore later changes to these inputs.
REQ-018 SHALL transition IDLE->DONE when N=0 or op is pass-through, and IDLE->SHIFT otherwise.
REQ-019 SHALL, in SHIFT, perform one 1-bit step of the captured op per clock and decrement the counter.
REQ-020 SHALL transition SHIFT->DONE on the edge that performs the N-th step.
REQ-021 SHALL set result to the final working value and drive done=1 for exactly one cycle while in DONE.
REQ-022 SHALL always transition DONE->IDLE on the next edge.
REQ-023 SHALL assert done N+1 cycles after the start cycle for N>0, and 1 cycle after it for N=0 or pass-through.
REQ-024 SHALL fill vacated positions with 0 for SLL and SRL.
REQ-025 SHALL replicate the MSB into vacated positions for SRA.
REQ-026 SHALL move the bit shifted out into the opposite end for ROL and ROR.
REQ-027 SHALL ignore start while busy=1, with no queueing.
REQ-028 SHALL hold result at its previous completed value while in IDLE and SHIFT, changing it only on entry to DONE.
REQ-029 SHALL produce result = data_in for N=DATA_W-1 with ROL followed by ROL 1 (wrap consistency).
REQ-030 SHALL treat a start asserted in the same cycle that DONE returns to IDLE as ignored; start is accepted from the next IDLE cycle.

Reset
REQ-031 SHALL, with reset=1 at a clock edge, force state IDLE, result=0, busy=0, done=0, counter=0, and working register=0.
REQ-032 SHALL let reset take priority over start and over any in-progress shift, abandoning that shift with no done pulse.

Verification
REQ-033 Bench SHALL check reset held 2 cycles -> result=0x00000000, busy=0, done=0.
REQ-034 Bench SHALL check SLL, shamt_sel=10, instr_shamt=4, data_in=0x000000F1 -> done 5 cycles after start, result=0x00000F10.
REQ-035 Bench SHALL check SRA, shamt_sel=00, b_data=0xFFFFFFE3 (amount 3), data_in=0x80000000 -> done after 4 cycles, result=0xF0000000.
REQ-036 Bench SHALL check ROR, shamt_sel=01, mem_data=0x00000021 (amount 1), data_in=0x00000001, with a second start pulse while busy -> done after 2 cycles, result=0x80000000, exactly one done pulse.
REQ-037 Bench SHALL check shamt_sel=11 with any op and data_in=0x12345678 -> done after 1 cycle, result=0x12345678.
REQ-038 Bench SHALL check reset asserted in the 3rd SHIFT cycle of SRL by 10 -> IDLE next cycle, result=0, no done pulse; a following SRL by 1 of 0x00000002 gives result=0x00000001.
